// File: rtl/i2c_pkg.sv
// ============================================================================
// Module      : i2c_pkg
// Description : Shared state encoding and SDA driver modes for the I2C slave.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE          = 4'd0,
        WAIT_FOR_BYTE = 4'd1,
        PREP_ACK      = 4'd2,
        ACK_TX        = 4'd3,
        LOAD_BYTE     = 4'd4,
        SEND_BYTE     = 4'd5,
        MAKE_BUS_IDLE = 4'd6,
        MASTER_ACK    = 4'd7,
        RX_WAIT       = 4'd8,
        ACK_RX        = 4'd9,
        RX_BYTE       = 4'd10,
        RX_ACK_PREP   = 4'd11,
        RX_REG_LOAD   = 4'd12,
        RX_KEY_SIGNAL = 4'd13
    } state_t;

    localparam logic [1:0] SDA_IDLE = 2'b00;
    localparam logic [1:0] SDA_ACK  = 2'b01;
    localparam logic [1:0] SDA_NACK = 2'b10;
    localparam logic [1:0] SDA_TX   = 2'b11;

endpackage

`default_nettype wire

// File: rtl/i2c_slave_controller.sv
// ============================================================================
// Module      : i2c_slave_controller
// Description : Moore FSM sequencing address, key receive and FIFO transmit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_slave_controller
    import i2c_pkg::*;
(
    input  logic       clk,
    input  logic       n_rst,
    input  logic       stop_found,
    input  logic       start_found,
    input  logic       byte_received,
    input  logic       ack_prep,
    input  logic       check_ack,
    input  logic       ack_done,
    input  logic       rw_mode,
    input  logic       address_match,
    input  logic       key_received,
    input  logic       sda_in,
    input  logic       fifo_empty,
    output logic       rx_enable,
    output logic       tx_enable,
    output logic       read_enable,
    output logic [1:0] sda_mode,
    output logic       load_data,
    output logic       reg_enable,
    output logic       start_byte_received,
    output logic       key_loaded
);

    state_t r_state;
    state_t w_next_state;
    logic   r_key_flag;
    logic   w_key_loaded;

    assign w_key_loaded = (r_state == RX_KEY_SIGNAL) || r_key_flag;

    // key_flag latches as RX_KEY_SIGNAL is left; that state never holds
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= IDLE;
            r_key_flag <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == RX_KEY_SIGNAL) begin
                r_key_flag <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:          if (start_found) w_next_state = WAIT_FOR_BYTE;
            WAIT_FOR_BYTE: if (byte_received) w_next_state = PREP_ACK;
            PREP_ACK: begin
                if (ack_prep) begin
                    if (!rw_mode && address_match && !w_key_loaded)
                        w_next_state = ACK_RX;
                    else if (rw_mode && address_match && w_key_loaded && !fifo_empty)
                        w_next_state = ACK_TX;
                    else
                        w_next_state = IDLE;
                end
            end
            ACK_RX:        if (ack_done) w_next_state = RX_BYTE;
            RX_BYTE:       if (byte_received) w_next_state = RX_ACK_PREP;
            RX_ACK_PREP: begin
                if (key_received)  w_next_state = RX_REG_LOAD;
                else if (ack_prep) w_next_state = ACK_RX;
            end
            RX_REG_LOAD:   w_next_state = RX_KEY_SIGNAL;
            RX_KEY_SIGNAL: w_next_state = IDLE;
            ACK_TX:        if (ack_done) w_next_state = LOAD_BYTE;
            LOAD_BYTE:     w_next_state = SEND_BYTE;
            SEND_BYTE:     if (ack_prep) w_next_state = MAKE_BUS_IDLE;
            MAKE_BUS_IDLE: if (check_ack) w_next_state = MASTER_ACK;
            MASTER_ACK: begin
                if (stop_found)   w_next_state = IDLE;
                else if (!sda_in) w_next_state = RX_WAIT;
            end
            RX_WAIT:       if (ack_done) w_next_state = LOAD_BYTE;
            default:       w_next_state = IDLE;
        endcase

        // Bus-level STOP / repeated START override any in-progress transfer
        if (r_state != IDLE) begin
            if (stop_found)       w_next_state = IDLE;
            else if (start_found) w_next_state = WAIT_FOR_BYTE;
        end
    end

    always_comb begin
        rx_enable           = 1'b0;
        tx_enable           = 1'b0;
        read_enable         = 1'b0;
        sda_mode            = SDA_IDLE;
        load_data           = 1'b0;
        reg_enable          = 1'b0;
        start_byte_received = 1'b0;
        key_loaded          = w_key_loaded;
        case (r_state)
            WAIT_FOR_BYTE, RX_BYTE: rx_enable = 1'b1;
            PREP_ACK:               start_byte_received = 1'b1;
            ACK_TX, ACK_RX:         sda_mode = SDA_ACK;
            LOAD_BYTE: begin
                read_enable = 1'b1;
                load_data   = 1'b1;
            end
            SEND_BYTE: begin
                tx_enable = 1'b1;
                sda_mode  = SDA_TX;
            end
            RX_REG_LOAD:            reg_enable = 1'b1;
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_i2c_slave_controller.sv
// ============================================================================
// Module      : tb_i2c_slave_controller
// Description : Directed self-checking bench for the I2C slave controller FSM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2c_slave_controller;
    import i2c_pkg::*;

    // Output vector: {rx,tx,rd,sda_mode[1:0],load,reg,start_byte,key}
    localparam logic [8:0] O_NONE = 9'h000;
    localparam logic [8:0] O_RXEN = 9'h100;
    localparam logic [8:0] O_SBR  = 9'h002;
    localparam logic [8:0] O_ACK  = 9'h010;
    localparam logic [8:0] O_LOAD = 9'h048;
    localparam logic [8:0] O_SEND = 9'h0B0;
    localparam logic [8:0] O_REG  = 9'h004;
    localparam logic [8:0] O_KEY  = 9'h001;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       stop_found, start_found, byte_received, ack_prep, check_ack, ack_done;
    logic       rw_mode, address_match, key_received, sda_in, fifo_empty;
    logic       rx_enable, tx_enable, read_enable, load_data, reg_enable;
    logic       start_byte_received, key_loaded;
    logic [1:0] sda_mode;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    i2c_slave_controller dut (
        .clk                 (clk),
        .n_rst               (n_rst),
        .stop_found          (stop_found),
        .start_found         (start_found),
        .byte_received       (byte_received),
        .ack_prep            (ack_prep),
        .check_ack           (check_ack),
        .ack_done            (ack_done),
        .rw_mode             (rw_mode),
        .address_match       (address_match),
        .key_received        (key_received),
        .sda_in              (sda_in),
        .fifo_empty          (fifo_empty),
        .rx_enable           (rx_enable),
        .tx_enable           (tx_enable),
        .read_enable         (read_enable),
        .sda_mode            (sda_mode),
        .load_data           (load_data),
        .reg_enable          (reg_enable),
        .start_byte_received (start_byte_received),
        .key_loaded          (key_loaded)
    );

    wire [8:0] outs = {rx_enable, tx_enable, read_enable, sda_mode, load_data,
                       reg_enable, start_byte_received, key_loaded};

    // One clock: pulses set beforehand are sampled, then cleared 1ns after the edge
    task automatic cyc();
        @(posedge clk);
        #1;
        stop_found    = 1'b0;
        start_found   = 1'b0;
        byte_received = 1'b0;
        ack_prep      = 1'b0;
        check_ack     = 1'b0;
        ack_done      = 1'b0;
        key_received  = 1'b0;
    endtask

    task automatic check(input string tag, input state_t exp_state, input logic [8:0] exp_outs);
        checks++;
        assert (outs === exp_outs) else begin
            errors++;
            $error("FAIL %s: outputs=%h expected=%h", tag, outs, exp_outs);
        end
        checks++;
        assert (dut.r_state === exp_state) else begin
            errors++;
            $error("FAIL %s: state=%0d expected=%0d", tag, dut.r_state, exp_state);
        end
    endtask

    // START + address byte, leaving the FSM in PREP_ACK
    task automatic address(input logic rw, input logic match, input logic [8:0] k);
        rw_mode = rw; address_match = match;
        start_found = 1'b1;   cyc(); check("addr_wait", WAIT_FOR_BYTE, O_RXEN | k);
        byte_received = 1'b1; cyc(); check("addr_prep", PREP_ACK, O_SBR | k);
        ack_prep = 1'b1;      cyc();
    endtask

    initial begin
        n_rst = 1'b0;
        stop_found = 0; start_found = 0; byte_received = 0; ack_prep = 0;
        check_ack = 0; ack_done = 0; key_received = 0;
        rw_mode = 0; address_match = 0; sda_in = 1; fifo_empty = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset", IDLE, O_NONE);
        n_rst = 1'b1;
        repeat (5) cyc();
        check("idle5", IDLE, O_NONE);

        // NACK cases before key load
        address(1'b0, 1'b0, O_NONE); check("nack_nomatch", IDLE, O_NONE);
        address(1'b1, 1'b1, O_NONE); check("nack_nokey", IDLE, O_NONE);

        // Key receive: 16 bytes
        address(1'b0, 1'b1, O_NONE); check("ack_rx", ACK_RX, O_ACK);
        for (int i = 0; i < 16; i++) begin
            ack_done = 1'b1;      cyc(); check("rx_byte", RX_BYTE, O_RXEN);
            byte_received = 1'b1; cyc(); check("rx_ack_prep", RX_ACK_PREP, O_NONE);
            if (i < 15) begin
                ack_prep = 1'b1;  cyc(); check("rx_ack", ACK_RX, O_ACK);
            end
        end
        key_received = 1'b1; ack_prep = 1'b1;
        cyc(); check("reg_load", RX_REG_LOAD, O_REG);
        cyc(); check("key_signal", RX_KEY_SIGNAL, O_KEY);
        cyc(); check("key_idle", IDLE, O_KEY);
        cyc(); check("key_sticky", IDLE, O_KEY);

        // After key load: write rejected, read with empty FIFO rejected
        address(1'b0, 1'b1, O_KEY); check("nack_write_after_key", IDLE, O_KEY);
        fifo_empty = 1'b1;
        address(1'b1, 1'b1, O_KEY); check("nack_fifo_empty", IDLE, O_KEY);
        fifo_empty = 1'b0;

        // Transmit 16 bytes
        address(1'b1, 1'b1, O_KEY); check("ack_tx", ACK_TX, O_ACK | O_KEY);
        ack_done = 1'b1; cyc(); check("load_byte", LOAD_BYTE, O_LOAD | O_KEY);
        cyc();                  check("send_byte", SEND_BYTE, O_SEND | O_KEY);
        cyc();                  check("send_hold", SEND_BYTE, O_SEND | O_KEY);
        ack_prep = 1'b1;  cyc(); check("bus_idle", MAKE_BUS_IDLE, O_KEY);
        check_ack = 1'b1; cyc(); check("master_ack", MASTER_ACK, O_KEY);
        for (int i = 0; i < 15; i++) begin
            sda_in = 1'b0;    cyc(); check("rx_wait", RX_WAIT, O_KEY);
            sda_in = 1'b1;
            ack_done = 1'b1;  cyc(); check("tx_load", LOAD_BYTE, O_LOAD | O_KEY);
            cyc();                   check("tx_send", SEND_BYTE, O_SEND | O_KEY);
            ack_prep = 1'b1;  cyc(); check("tx_bus_idle", MAKE_BUS_IDLE, O_KEY);
            check_ack = 1'b1; cyc(); check("tx_master_ack", MASTER_ACK, O_KEY);
        end
        sda_in = 1'b1;      cyc(); check("master_nack_hold", MASTER_ACK, O_KEY);
        stop_found = 1'b1;  cyc(); check("stop_idle", IDLE, O_KEY);

        // Asynchronous reset clears the sticky key flag immediately
        n_rst = 1'b0; #1;
        check("async_reset", IDLE, O_NONE);
        @(posedge clk); #1;
        n_rst = 1'b1;
        cyc(); check("after_reset", IDLE, O_NONE);

        // STOP during RX_BYTE, then repeated START from RX_BYTE
        address(1'b0, 1'b1, O_NONE); check("ack_rx2", ACK_RX, O_ACK);
        ack_done = 1'b1;   cyc(); check("rx_byte2", RX_BYTE, O_RXEN);
        stop_found = 1'b1; start_found = 1'b1;
        cyc(); check("stop_in_rx", IDLE, O_NONE);
        address(1'b0, 1'b1, O_NONE); check("ack_rx3", ACK_RX, O_ACK);
        ack_done = 1'b1;    cyc(); check("rx_byte3", RX_BYTE, O_RXEN);
        start_found = 1'b1; cyc(); check("restart_in_rx", WAIT_FOR_BYTE, O_RXEN);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/i2c_slave_controller.md
# i2c_slave_controller

Main Moore state machine of the I2C slave. It sequences address-byte reception, ACK/NACK, a 16-byte key receive phase and a transmit phase that streams FIFO data back to the master. It sits between the bus-level blocks (start/stop detector, shift registers, timer, SDA driver) and the key register and FIFO.

## Interface
Parameters: none.

Clock and reset (already decided): one clock; reset is asynchronous and active-low.

- clk  in  1  system clock; all state changes on rising edge
- n_rst  in  1  asynchronous active-low reset
- stop_found  in  1  STOP condition detected (1-cycle pulse)
- start_found  in  1  START condition detected (1-cycle pulse)
- byte_received  in  1  rx shift register holds a full byte
- ack_prep  in  1  timer: ACK/NACK bit slot about to begin
- check_ack  in  1  timer: master ACK bit slot reached
- ack_done  in  1  timer: ACK bit slot finished
- rw_mode  in  1  R/W bit of address byte (1 = master reads)
- address_match  in  1  address byte matches slave address
- key_received  in  1  16th key byte complete
- sda_in  in  1  synchronized SDA line
- fifo_empty  in  1  transmit FIFO empty
- rx_enable  out  1  enable rx shift register
- tx_enable  out  1  enable tx shift register
- read_enable  out  1  pop transmit FIFO
- sda_mode  out  2  00 release, 01 drive ACK (low), 10 drive NACK (unused), 11 drive tx data
- load_data  out  1  load tx shift register
- reg_enable  out  1  latch key register
- start_byte_received  out  1  address byte captured, evaluate address/R/W
- key_loaded  out  1  sticky: key loaded since reset

## Operation
- State encoding (4 bits): IDLE 0, WAIT_FOR_BYTE 1, PREP_ACK 2, ACK_TX 3, LOAD_BYTE 4, SEND_BYTE 5, MAKE_BUS_IDLE 6, MASTER_ACK 7, RX_WAIT 8, ACK_RX 9, RX_BYTE 10, RX_ACK_PREP 11, RX_REG_LOAD 12, RX_KEY_SIGNAL 13.
- Moore outputs (all others 0):
  - WAIT_FOR_BYTE and RX_BYTE: rx_enable.
  - PREP_ACK: start_byte_received.
  - ACK_TX and ACK_RX: sda_mode=01.
  - LOAD_BYTE: read_enable, load_data.
  - SEND_BYTE: tx_enable, sda_mode=11.
  - RX_REG_LOAD: reg_enable.
  - RX_KEY_SIGNAL: key_loaded.
- key_loaded = (state==RX_KEY_SIGNAL) OR key_flag. key_flag is set on the edge leaving RX_KEY_SIGNAL and cleared only by reset.
- Transitions; a state holds when no listed condition is true:
  - IDLE: start_found → WAIT_FOR_BYTE.
  - WAIT_FOR_BYTE: byte_received → PREP_ACK.
  - PREP_ACK on ack_prep:
    - rw_mode=0 & address_match & !key_loaded → ACK_RX.
    - rw_mode=1 & address_match & key_loaded & !fifo_empty → ACK_TX.
    - otherwise → IDLE (NACK: SDA released).
  - ACK_RX: ack_done → RX_BYTE.
  - RX_BYTE: byte_received → RX_ACK_PREP.
  - RX_ACK_PREP: key_received → RX_REG_LOAD (priority); else ack_prep → ACK_RX.
  - RX_REG_LOAD → RX_KEY_SIGNAL → IDLE, unconditional.
  - ACK_TX: ack_done → LOAD_BYTE.
  - LOAD_BYTE → SEND_BYTE, unconditional.
  - SEND_BYTE: ack_prep → MAKE_BUS_IDLE.
  - MAKE_BUS_IDLE: check_ack → MASTER_ACK.
  - MASTER_ACK: stop_found → IDLE; else sda_in=0 (master ACK) → RX_WAIT; else hold (NACK, wait for STOP).
  - RX_WAIT: ack_done → LOAD_BYTE.
- Global rules, from any non-IDLE state:
  - stop_found → IDLE, highest priority.
  - Otherwise start_found (repeated START) → WAIT_FOR_BYTE.

## Timing
- Reset: state=IDLE, key_flag=0, so every output is 0 and sda_mode=00.
- Outputs are decoded from the registered state only and are valid in the same cycle as the state. There is no output register.
- A 1-cycle input pulse sampled at rising edge N changes the state, and therefore the outputs, after edge N.
- LOAD_BYTE, RX_REG_LOAD and RX_KEY_SIGNAL each last exactly one cycle.
- Reset asserted mid-transaction returns the block to IDLE immediately and clears key_loaded.

## Structure
- Shared package `i2c_pkg`: state enum (encodings above) and sda_mode constants (SDA_IDLE, SDA_ACK, SDA_NACK, SDA_TX).
- Single module, no sub-modules: state register, key_flag register, next-state logic and output decode.

## Test plan
- Reset, 5 idle cycles → IDLE, all outputs 0.
- start, byte_received, then ack_prep with rw=0, match=0 → WAIT_FOR_BYTE (rx_enable=1), PREP_ACK (start_byte_received=1), IDLE. Repeat with rw=1, match=1, key not loaded → IDLE.
- Key load:
  - Address with rw=0, match=1 → ACK_RX (sda_mode=01).
  - 16× (ack_done→RX_BYTE, byte_received→RX_ACK_PREP, ack_prep→ACK_RX).
  - key_received → RX_REG_LOAD (reg_enable=1), RX_KEY_SIGNAL (key_loaded=1), IDLE with key_loaded held at 1.
- After key loaded: rw=0, match=1 → IDLE. rw=1, match=1, fifo_empty=1 → IDLE.
- Transmit with rw=1, match=1, fifo_empty=0 → ACK_TX → LOAD_BYTE (read_enable=1, load_data=1) → SEND_BYTE (tx_enable=1, sda_mode=11) → MAKE_BUS_IDLE → MASTER_ACK. Then sda_in=0 → RX_WAIT, ack_done → LOAD_BYTE. Repeat 16 times. Final byte: sda_in=1 holds MASTER_ACK, stop_found → IDLE.
- Reset after key load → key_loaded=0. stop_found during RX_BYTE → IDLE.
